// File: rtl/scan_pkg.sv
// Shared types and constants for the multiplexed hex-digit scanner.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } scan_state_t;

   localparam logic [1:0] ENA_ON  = 2'b10;
   localparam logic [1:0] ENA_OFF = 2'b00;

   function automatic logic [3:0] pick_nibble(input logic [31:0] word, input logic [2:0] idx);
      return word[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/scan_tick.sv
// Digit-time prescaler: counts 0..DIV-1 and flags the terminal count for one cycle.
module scan_tick #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || (cnt == TERM)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = !clear && (cnt == TERM);

endmodule

// File: rtl/digit_scanner.sv
// Eight-digit display scanner with a frame-latched shadow of the digit word.
// Optional inter-digit dark gap compiled in with macro SCAN_BLANK_EN.
//
// state | meaning
// IDLE  | scan disabled, display dark, digit index 0
// SHOW  | current digit lit for DIV cycles
// BLANK | digit dark for BLANK_CYC cycles before the index advances
module digit_scanner
   import scan_pkg::*;
#(
   parameter int unsigned DIV = 100000
`ifdef SCAN_BLANK_EN
   , parameter int unsigned BLANK_CYC = 16
`endif
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEn,
   input  logic [31:0] iDigits,
   output logic [2:0]  oSel,
   output logic [1:0]  oEna,
   output logic [3:0]  oHex,
   output logic        oFrame
);

   scan_state_t state, state_n;
   logic [31:0] shadow, shadow_n;
   logic [2:0]  sel_n;
   logic [1:0]  ena_n;
   logic [3:0]  hex_n;
   logic        frame_n;
   logic        advance;
   logic        clear;
   logic        tick;

`ifdef SCAN_BLANK_EN
   localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
   logic [7:0] blank_cnt, blank_n;
`endif

   assign clear = (state != SHOW) || !iEn;

   scan_tick #(.DIV(DIV)) u_tick (
      .clk   (iClk),
      .rst   (iRst),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state  <= IDLE;
         shadow <= '0;
         oSel   <= '0;
         oEna   <= ENA_OFF;
         oHex   <= '0;
         oFrame <= 1'b0;
`ifdef SCAN_BLANK_EN
         blank_cnt <= '0;
`endif
      end else begin
         state  <= state_n;
         shadow <= shadow_n;
         oSel   <= sel_n;
         oEna   <= ena_n;
         oHex   <= hex_n;
         oFrame <= frame_n;
`ifdef SCAN_BLANK_EN
         blank_cnt <= blank_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      shadow_n = shadow;
      sel_n    = oSel;
      ena_n    = oEna;
      frame_n  = 1'b0;
      advance  = 1'b0;
`ifdef SCAN_BLANK_EN
      blank_n  = blank_cnt;
`endif
      if (!iEn) begin
         state_n = IDLE;
         sel_n   = '0;
         ena_n   = ENA_OFF;
`ifdef SCAN_BLANK_EN
         blank_n = '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state_n  = SHOW;
               sel_n    = '0;
               ena_n    = ENA_ON;
               shadow_n = iDigits;
            end
            SHOW: begin
               if (tick) begin
`ifdef SCAN_BLANK_EN
                  state_n = BLANK;
                  ena_n   = ENA_OFF;
                  blank_n = '0;
`else
                  advance = 1'b1;
`endif
               end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
               if (blank_cnt == BLANK_LAST) begin
                  advance = 1'b1;
               end else begin
                  blank_n = blank_cnt + 8'd1;
               end
            end
`endif
            default: begin
               state_n = IDLE;
               sel_n   = '0;
               ena_n   = ENA_OFF;
            end
         endcase

         // Shadow is only refreshed on the 7->0 wrap so a frame never shows mixed data.
         if (advance) begin
            state_n = SHOW;
            ena_n   = ENA_ON;
            sel_n   = oSel + 3'd1;
            if (oSel == 3'd7) begin
               shadow_n = iDigits;
               frame_n  = 1'b1;
            end
         end
      end
      hex_n = pick_nibble(shadow_n, sel_n);
   end

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_digit_scanner;
   import scan_pkg::*;

`ifdef SCAN_BLANK_EN
   localparam int P4 = 6;
   localparam int P1 = 2;
`else
   localparam int P4 = 4;
   localparam int P1 = 1;
`endif
   localparam int ON4 = 4;
   localparam int ON1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en4 = 1'b0, en1 = 1'b0;
   logic [31:0] digits4 = '0, digits1 = '0;
   logic [2:0]  sel4, sel1;
   logic [1:0]  ena4, ena1;
   logic [3:0]  hex4, hex1;
   logic        frame4, frame1;

   always #5 clk = ~clk;

   digit_scanner #(
      .DIV(4)
`ifdef SCAN_BLANK_EN
      , .BLANK_CYC(2)
`endif
   ) u_div4 (
      .iClk(clk), .iRst(rst), .iEn(en4), .iDigits(digits4),
      .oSel(sel4), .oEna(ena4), .oHex(hex4), .oFrame(frame4)
   );

   digit_scanner #(
      .DIV(1)
`ifdef SCAN_BLANK_EN
      , .BLANK_CYC(1)
`endif
   ) u_div1 (
      .iClk(clk), .iRst(rst), .iEn(en1), .iDigits(digits1),
      .oSel(sel1), .oEna(ena1), .oHex(hex1), .oFrame(frame1)
   );

   typedef struct {
      bit         which;
      logic [2:0] sel;
      logic [1:0] ena;
      logic [3:0] hex;
      logic       frame;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(string nm, string fld, int got, int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s %s got=%0d want=%0d at %0t", nm, fld, got, want, $time);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         if (mon_e.which) begin
            chk(mon_e.nm, "sel",   int'(sel1),   int'(mon_e.sel));
            chk(mon_e.nm, "ena",   int'(ena1),   int'(mon_e.ena));
            chk(mon_e.nm, "hex",   int'(hex1),   int'(mon_e.hex));
            chk(mon_e.nm, "frame", int'(frame1), int'(mon_e.frame));
         end else begin
            chk(mon_e.nm, "sel",   int'(sel4),   int'(mon_e.sel));
            chk(mon_e.nm, "ena",   int'(ena4),   int'(mon_e.ena));
            chk(mon_e.nm, "hex",   int'(hex4),   int'(mon_e.hex));
            chk(mon_e.nm, "frame", int'(frame4), int'(mon_e.frame));
         end
      end
   end

   function automatic int nib(logic [31:0] w, int s);
      return int'(w[4*s +: 4]);
   endfunction

   // Waits for the next edge and queues what the selected DUT must show during the following cycle.
   task automatic step(bit w, int s, logic [1:0] en, int h, bit fr, string nm);
      exp_t e;
      @(posedge clk);
      #1;
      e.which = w;
      e.sel   = 3'(s);
      e.ena   = en;
      e.hex   = 4'(h);
      e.frame = fr;
      e.nm    = nm;
      sb.push_back(e);
   endtask

   // Scan of ncyc cycles from the first edge after enable; d1 is driven after cycle chg_at.
   task automatic scan_run(bit w, int p, int on, logic [31:0] d0, logic [31:0] d1,
                           int chg_at, int ncyc, string nm);
      int s;
      for (int c = 0; c < ncyc; c++) begin
         s = (c / p) % 8;
         step(w, s, ((c % p) < on) ? ENA_ON : ENA_OFF,
              (c < 8*p) ? nib(d0, s) : nib(d1, s),
              (c > 0) && ((c % (8*p)) == 0), nm);
         if (c == chg_at) begin
            if (w) digits1 = d1;
            else   digits4 = d1;
         end
      end
   endtask

   initial begin
      int guard;
      #1 rst = 1'b1;
      #1;
      chk("reset", "sel4", int'(sel4), 0);
      chk("reset", "ena4", int'(ena4), 0);
      chk("reset", "hex4", int'(hex4), 0);
      chk("reset", "frame4", int'(frame4), 0);
      chk("reset", "sel1", int'(sel1), 0);
      chk("reset", "ena1", int'(ena1), 0);
      #1 rst = 1'b0;
      step(0, 0, ENA_OFF, 0, 0, "idle4");
      step(1, 0, ENA_OFF, 0, 0, "idle1");

      // full frame, then digits changed while digit 3 is shown
      digits4 = 32'h7654_3210;
      en4 = 1'b1;
      scan_run(0, P4, ON4, 32'h7654_3210, 32'hFFFF_FFFF, 3*P4 + 1, 8*P4 + 8, "frame4");
      en4 = 1'b0;
      step(0, 0, ENA_OFF, 15, 0, "stop4");

      // enable dropped while digit 5 is shown, then restart with a fresh word
      digits4 = 32'h1234_ABCD;
      en4 = 1'b1;
      scan_run(0, P4, ON4, 32'h1234_ABCD, 32'h1234_ABCD, -1, 5*P4 + 2, "drop4");
      en4 = 1'b0;
      step(0, 0, ENA_OFF, 13, 0, "drop_idle");
      digits4 = 32'h0000_0005;
      step(0, 0, ENA_OFF, 13, 0, "shadow_kept");
      en4 = 1'b1;
      step(0, 0, ENA_ON, 5, 0, "reload");
      step(0, 0, ENA_ON, 5, 0, "reload");
      en4 = 1'b0;
      step(0, 0, ENA_OFF, 5, 0, "reload_idle");

      // asynchronous reset between edges while digit 2 is lit
      digits4 = 32'h7654_3210;
      en4 = 1'b1;
      scan_run(0, P4, ON4, 32'h7654_3210, 32'h7654_3210, -1, 2*P4 + 1, "pre_rst");
      step(0, 0, ENA_OFF, 0, 0, "rst_async");
      #2 rst = 1'b1;
      #1;
      chk("rst_async", "sel", int'(sel4), 0);
      chk("rst_async", "ena", int'(ena4), 0);
      chk("rst_async", "hex", int'(hex4), 0);
      chk("rst_async", "frame", int'(frame4), 0);
      en4 = 1'b0;
      #2 rst = 1'b0;
      step(0, 0, ENA_OFF, 0, 0, "rst_idle");
      step(0, 0, ENA_OFF, 0, 0, "rst_idle");
      en4 = 1'b1;
      scan_run(0, P4, ON4, 32'h7654_3210, 32'h7654_3210, -1, P4 + 1, "restart");
      en4 = 1'b0;
      step(0, 0, ENA_OFF, 0, 0, "restart_idle");

      // single-cycle digit time
      digits1 = 32'hFEDC_BA98;
      en1 = 1'b1;
      scan_run(1, P1, ON1, 32'hFEDC_BA98, 32'hFEDC_BA98, -1, 16*P1 + 2, "div1");
      en1 = 1'b0;
      step(1, 0, ENA_OFF, 8, 0, "div1_idle");

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
